// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter generator: control-flow kinds,
// branch condition selects and the next-PC source select.
package pc_pkg;

  localparam logic [1:0] MTR_JAL  = 2'b10;
  localparam logic [1:0] MTR_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_TARGET,
    NPC_TRAP,
    NPC_HOLD
  } npc_sel_e;

  // funct3 values 010/011 are not branch conditions and never redirect.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       zero_flag,
                                       input logic       lt_flag,
                                       input logic       ltu_flag);
    logic cond;
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero_flag;
      F3_BNE:  cond = !zero_flag;
      F3_BLT:  cond = lt_flag;
      F3_BGE:  cond = !lt_flag;
      F3_BLTU: cond = ltu_flag;
      F3_BGEU: cond = !ltu_flag;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control-flow inputs and PC outputs of pc_gen. The master side is the core
// decode/execute logic; the slave side is the PC generator itself.
interface pc_gen_if #(
  parameter int PC_W  = 10,
  parameter int IMM_W = 21,
  parameter int XLEN  = 32
);

  logic             stall;
  logic             branch;
  logic [2:0]       funct3;
  logic             zero_flag;
  logic             lt_flag;
  logic             ltu_flag;
  logic [1:0]       mem_to_reg;
  logic [IMM_W-1:0] immediate;
  logic [XLEN-1:0]  reg_out1;
  logic             ras_push;
  logic             ras_pop;

  logic [PC_W-1:0]  pc_out;
  logic [PC_W-1:0]  pc_plus4;
  logic             taken;
  logic             misalign_err;
  logic [PC_W-1:0]  ras_top;
  logic             ras_valid;

  modport master (
    output stall, branch, funct3, zero_flag, lt_flag, ltu_flag,
           mem_to_reg, immediate, reg_out1, ras_push, ras_pop,
    input  pc_out, pc_plus4, taken, misalign_err, ras_top, ras_valid
  );

  modport slave (
    input  stall, branch, funct3, zero_flag, lt_flag, ltu_flag,
           mem_to_reg, immediate, reg_out1, ras_push, ras_pop,
    output pc_out, pc_plus4, taken, misalign_err, ras_top, ras_valid
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack used by pc_gen when PC_RAS_EN is defined.
// DEPTH must be a power of two so the pointer wraps on its own.
module pc_ras #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign top_idx = ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign valid   = !empty;
  assign top     = empty ? '0 : stack[top_idx];

  // A push paired with a pop on a non-empty stack replaces the top entry in
  // place; a lone pop on an empty stack does nothing.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = ptr;
    if (!reset && push) begin
      wr_en = 1'b1;
      if (pop && !empty) wr_idx = top_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Parametrised program-counter generator for the single-cycle RV32 core.
// Define PC_RAS_EN to add the return-address stack (pc_ras) for jalr returns.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              PC_W      = 10,
  parameter int              IMM_W     = 21,
  parameter int              XLEN      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  // Targets are formed at the wider of the data and PC widths, then truncated.
  localparam int AW = (XLEN > PC_W) ? XLEN : PC_W;

  logic [PC_W-1:0] pc_q;
  logic            misalign_q;
  logic [PC_W-1:0] pc_plus4;
  logic [AW-1:0]   imm_ext;
  logic [AW-1:0]   base;
  logic [AW-1:0]   target_full;
  logic [PC_W-1:0] target;
  logic            is_jump;
  logic            is_jalr;
  logic            taken;
  logic            misaligned;
  logic            ras_push_en;
  logic            ras_pop_en;
  logic            unused_target;
  npc_sel_e        npc_sel;

  assign imm_ext  = AW'(signed'(bus.immediate));
  assign pc_plus4 = pc_q + PC_W'(4);
  assign is_jump  = bus.branch && (bus.mem_to_reg == MTR_JAL || bus.mem_to_reg == MTR_JALR);
  assign is_jalr  = bus.branch && (bus.mem_to_reg == MTR_JALR);
  assign taken    = bus.branch &&
                    (is_jump || branch_cond(bus.funct3, bus.zero_flag, bus.lt_flag, bus.ltu_flag));

  always_comb begin
    base = AW'(pc_q);
    if (is_jalr) base = AW'(bus.reg_out1);
    target_full = base + imm_ext;
    if (is_jalr) target_full[0] = 1'b0;
  end

  assign target        = target_full[PC_W-1:0];
  assign misaligned    = taken && target[1];
  assign unused_target = ^target_full;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (bus.stall)       npc_sel = NPC_HOLD;
    else if (misaligned) npc_sel = NPC_TRAP;
    else if (taken)      npc_sel = NPC_TARGET;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (npc_sel == NPC_TRAP);
      unique case (npc_sel)
        NPC_HOLD:   pc_q <= pc_q;
        NPC_TRAP:   pc_q <= TRAP_VEC;
        NPC_TARGET: pc_q <= target;
        NPC_SEQ:    pc_q <= pc_plus4;
      endcase
    end
  end

  // The stack only moves on a redirect that actually commits.
  assign ras_push_en = (npc_sel == NPC_TARGET) && is_jump && bus.ras_push;
  assign ras_pop_en  = (npc_sel == NPC_TARGET) && is_jalr && bus.ras_pop;

`ifdef PC_RAS_EN
  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_data (pc_plus4),
    .top       (bus.ras_top),
    .valid     (bus.ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras    = ras_push_en ^ ras_pop_en;
  assign bus.ras_top   = '0;
  assign bus.ras_valid = 1'b0;
`endif

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.taken        = taken;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed walk through the plan, then random
// cycles against a behavioural model. Define PC_RAS_EN to cover the stack.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int              PC_W      = 10;
  localparam int              IMM_W     = 21;
  localparam int              XLEN      = 32;
  localparam int              RAS_DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_VEC = 10'd0;
  localparam logic [PC_W-1:0] TRAP_VEC  = 10'h200;
  localparam longint          MASK      = (longint'(1) << PC_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pc_gen_if #(.PC_W(PC_W), .IMM_W(IMM_W), .XLEN(XLEN)) bus ();

  pc_gen #(
    .PC_W(PC_W), .IMM_W(IMM_W), .XLEN(XLEN),
    .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     compared   = 0;
  int     mismatched = 0;
  longint m_pc;
  bit     m_err;
  longint m_ras[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input bit rst, input bit stl, input bit br,
                               input logic [2:0] f3, input bit z, input bit lt,
                               input bit ltu, input logic [1:0] mtr,
                               input longint imm, input longint r1,
                               input bit push, input bit pop);
    reset          = rst;
    bus.stall      = stl;
    bus.branch     = br;
    bus.funct3     = f3;
    bus.zero_flag  = z;
    bus.lt_flag    = lt;
    bus.ltu_flag   = ltu;
    bus.mem_to_reg = mtr;
    bus.immediate  = IMM_W'(imm);
    bus.reg_out1   = XLEN'(r1);
    bus.ras_push   = push;
    bus.ras_pop    = pop;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle(input string tag);
    longint imm, tgt, p4;
    bit     cond, tk;
    #1;
    imm = longint'($signed(bus.immediate));
    case (bus.funct3)
      3'b000:  cond = bus.zero_flag;
      3'b001:  cond = !bus.zero_flag;
      3'b100:  cond = bus.lt_flag;
      3'b101:  cond = !bus.lt_flag;
      3'b110:  cond = bus.ltu_flag;
      3'b111:  cond = !bus.ltu_flag;
      default: cond = 1'b0;
    endcase
    tk = bus.branch && (bus.mem_to_reg[1] || cond);
    if (bus.mem_to_reg == MTR_JALR)
      tgt = ((longint'(bus.reg_out1) + imm) & MASK) & ~longint'(1);
    else
      tgt = (m_pc + imm) & MASK;
    p4 = (m_pc + 4) & MASK;
    checkOutput({tag, ".taken"}, bus.taken, tk);
    checkOutput({tag, ".pc_plus4"}, bus.pc_plus4, p4);

    if (reset) begin
      m_pc = RESET_VEC; m_err = 0; m_ras.delete();
    end else if (bus.stall) begin
      m_err = 0;
    end else if (tk && tgt[1]) begin
      m_pc = TRAP_VEC; m_err = 1;
    end else if (tk) begin
`ifdef PC_RAS_EN
      if (bus.mem_to_reg[1]) begin
        bit push, pop;
        push = bus.ras_push;
        pop  = bus.ras_pop && bus.mem_to_reg == MTR_JALR;
        if (push && pop && m_ras.size() != 0) m_ras[m_ras.size()-1] = p4;
        else if (push) begin
          m_ras.push_back(p4);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (pop && m_ras.size() != 0) void'(m_ras.pop_back());
      end
`endif
      m_pc = tgt; m_err = 0;
    end else begin
      m_pc = p4; m_err = 0;
    end

    @(posedge clk);
    #1;
    checkOutput({tag, ".pc_out"}, bus.pc_out, m_pc);
    checkOutput({tag, ".misalign_err"}, bus.misalign_err, m_err);
    checkOutput({tag, ".ras_valid"}, bus.ras_valid, m_ras.size() != 0);
    checkOutput({tag, ".ras_top"}, bus.ras_top, m_ras.size() != 0 ? m_ras[$] : 0);
  endtask

  initial begin
    longint imm, r1;
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    m_pc = RESET_VEC; m_err = 0;

    // Reset then sequential fetch.
    cycle("reset");
    checkOutput("reset.pc", bus.pc_out, 0);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cycle("seq1"); checkOutput("seq1.pc", bus.pc_out, 4);
    cycle("seq2"); checkOutput("seq2.pc", bus.pc_out, 8);
    cycle("seq3"); checkOutput("seq3.pc", bus.pc_out, 12);

    // Conditional branches.
    applyStimulus(0, 0, 1, F3_BEQ, 1, 0, 0, 2'b00, 196, 0, 0, 0);
    cycle("beq_t"); checkOutput("beq_t.pc", bus.pc_out, 208);
    applyStimulus(0, 0, 1, F3_BEQ, 0, 0, 0, 2'b00, 196, 0, 0, 0);
    cycle("beq_nt"); checkOutput("beq_nt.pc", bus.pc_out, 212);
    applyStimulus(0, 0, 1, F3_BLTU, 0, 0, 1, 2'b00, -8, 0, 0, 0);
    cycle("bltu"); checkOutput("bltu.pc", bus.pc_out, 204);

    // jal then wrap-around.
    applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JAL, 804, 0, 0, 0);
    cycle("jal"); checkOutput("jal.pc", bus.pc_out, 1008);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cycle("wrap1"); cycle("wrap2"); cycle("wrap3");
    checkOutput("wrap3.pc", bus.pc_out, 1020);
    cycle("wrap4"); checkOutput("wrap4.pc", bus.pc_out, 0);

    // Misaligned jalr traps, aligned jalr does not.
    applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JALR, 20, 15, 0, 0);
    cycle("jalr_mis"); checkOutput("jalr_mis.pc", bus.pc_out, TRAP_VEC);
    checkOutput("jalr_mis.err", bus.misalign_err, 1);
    applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JALR, 20, 16, 0, 0);
    cycle("jalr_ok"); checkOutput("jalr_ok.pc", bus.pc_out, 36);
    checkOutput("jalr_ok.err", bus.misalign_err, 0);

    // Stall holds PC and clears the error pulse.
    applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JALR, 20, 15, 0, 0);
    cycle("pre_stall");
    applyStimulus(0, 1, 1, 3'b000, 0, 0, 0, MTR_JAL, 800, 0, 0, 0);
    cycle("stall1"); checkOutput("stall1.err", bus.misalign_err, 0);
    cycle("stall2"); cycle("stall3");
    checkOutput("stall3.pc", bus.pc_out, TRAP_VEC);
    applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JAL, 800, 0, 0, 0);
    cycle("unstall"); checkOutput("unstall.pc", bus.pc_out, 288);
    applyStimulus(1, 1, 1, 3'b000, 0, 0, 0, MTR_JAL, 800, 0, 0, 0);
    cycle("rst_stall"); checkOutput("rst_stall.pc", bus.pc_out, RESET_VEC);

    // Return-address stack: five calls, then returns.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JAL, 100, 0, 1, 0);
      cycle("call");
    end
`ifdef PC_RAS_EN
    checkOutput("call.top", bus.ras_top, 404);
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 3'b000, 0, 0, 0, MTR_JALR, 0, 404 - 100 * i, 0, 1);
      cycle("ret");
    end
    checkOutput("ret.empty", bus.ras_valid, 0);

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = longint'($urandom_range(0, 1023)) * 4 - 2048;
        1:       imm = longint'($urandom_range(0, 4095)) - 2048;
        2:       imm = longint'($urandom_range(0, (1 << IMM_W) - 1)) - (1 << (IMM_W - 1));
        default: imm = longint'($urandom_range(0, 63)) * 4;
      endcase
      r1 = longint'($urandom);
      if ($urandom_range(0, 1) == 1) r1 = r1 & ~longint'(3);
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 2'($urandom), imm, r1,
                    1'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
